// File: rtl/wishbone_fetch_master_pkg.sv
// rtl/wishbone_fetch_master_pkg.sv - fetch state, NOP constant and FIFO entry type (err field under WB_FETCH_TIMEOUT_EN)
package wb_fetch_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GAP     = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
`ifdef WB_FETCH_TIMEOUT_EN
    logic        err;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/wishbone_fetch_master_if.sv
// rtl/wishbone_fetch_master_if.sv - read-only Wishbone classic bus between fetch master and instruction RAM
interface wishbone_interface;
  logic        cyc;
  logic        stb;
  logic [31:0] adr;
  logic        ack;
  logic [31:0] dat_miso;

  modport master (output cyc, stb, adr, input ack, dat_miso);
  modport slave  (input cyc, stb, adr, output ack, dat_miso);
endinterface

// File: rtl/wishbone_fetch_master_fifo.sv
// rtl/wishbone_fetch_master_fifo.sv - synchronous prefetch FIFO of fetch entries with flush
module fetch_fifo
  import wb_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit separates full (MSBs differ) from empty (all equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

endmodule

// File: rtl/wishbone_fetch_master.sv
// rtl/wishbone_fetch_master.sv - Wishbone instruction fetch master with prefetch FIFO and redirect; WB_FETCH_TIMEOUT_EN adds ack timeout and bus_err
module wishbone_fetch_master
  import wb_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  wishbone_interface.master port_a,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [31:0]       instr_pc,
  output logic              busy
`ifdef WB_FETCH_TIMEOUT_EN
  ,
  output logic              bus_err
`endif
);

  fetch_state_t state, next_state;
  logic [31:0]  pc, pc_d;
  logic [31:0]  adr;
  logic         cyc, stb, stb_prev;
  logic         bus_on;
  logic         ack_ok;
  logic         timeout;
  logic         can_start;
  logic         push;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         fifo_empty, fifo_full;
  logic [31:0]  redirect_target;

  assign redirect_target = redirect_pc & ~32'h3;
  // An ack only counts once stb has been up for a full cycle; this rejects
  // a stale re-latched ack arriving just as a new strobe rises.
  assign ack_ok    = port_a.ack && stb && stb_prev;
  assign can_start = fetch_en && !fifo_full;
  assign bus_on    = (next_state == REQ) || (next_state == DISCARD);

`ifdef WB_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign timeout = (tmo_cnt == TW'(TIMEOUT - 1)) && !ack_ok;

  always_ff @(posedge clk) begin
    if (!rst || !((state == REQ) || (state == DISCARD))) tmo_cnt <= '0;
    else                                                 tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    next_state      = state;
    pc_d            = pc;
    push            = 1'b0;
    push_entry      = '0;
    push_entry.pc   = pc;
    push_entry.data = port_a.dat_miso;
    case (state)
      IDLE: begin
        if (redirect_valid)  pc_d = redirect_target;
        else if (can_start)  next_state = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          next_state = (ack_ok || timeout) ? GAP : DISCARD;
        end else if (ack_ok) begin
          push       = 1'b1;
          pc_d       = pc + 32'd4;
          next_state = GAP;
        end else if (timeout) begin
          push            = 1'b1;
          push_entry.data = NOP;
`ifdef WB_FETCH_TIMEOUT_EN
          push_entry.err  = 1'b1;
`endif
          pc_d            = pc + 32'd4;
          next_state      = GAP;
        end
      end
      DISCARD: begin
        if (redirect_valid)     pc_d = redirect_target;
        if (ack_ok || timeout)  next_state = GAP;
      end
      GAP: begin
        if (redirect_valid) begin
          pc_d       = redirect_target;
          next_state = IDLE;
        end else begin
          next_state = can_start ? REQ : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      adr      <= RESET_PC;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      stb_prev <= 1'b0;
    end else begin
      state    <= next_state;
      pc       <= pc_d;
      cyc      <= bus_on;
      stb      <= bus_on;
      stb_prev <= stb;
      if ((state == IDLE || state == GAP) && next_state == REQ) adr <= pc;
    end
  end

  assign port_a.cyc = cyc;
  assign port_a.stb = stb;
  assign port_a.adr = adr;
  assign busy       = cyc;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push && !redirect_valid),
    .push_entry (push_entry),
    .pop        (instr_ready && !redirect_valid),
    .flush      (redirect_valid),
    .head       (head),
    .empty      (fifo_empty),
    .full       (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = fifo_empty ? 32'h0 : head.data;
  assign instr_pc    = fifo_empty ? 32'h0 : head.pc;
`ifdef WB_FETCH_TIMEOUT_EN
  assign bus_err     = !fifo_empty && head.err;
`endif

endmodule
